// File: rtl/wb_pkg.sv
// wb_pkg: Wishbone constants and DMA copy FSM state type.
package wb_pkg;
    localparam logic [3:0] SEL_ALL    = 4'hF;
    localparam int         WORD_SHIFT = 2;

    typedef enum logic [2:0] {IDLE, RD, WR, GAP, FIN} dma_state_t;

    function automatic logic [31:0] word_adr(input logic [29:0] ptr);
        return {ptr, {WORD_SHIFT{1'b0}}};
    endfunction
endpackage

// File: rtl/wb_dma_copy.sv
// wb_dma_copy: Wishbone master copying a block of words, one read then one write per word.
module wb_dma_copy
    import wb_pkg::*;
#(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [31:0]      src_i,
    input  logic [31:0]      dst_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [LEN_W-1:0] words_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    output logic [3:0]       wbm_sel_o,
    output logic             wbm_we_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i
);
    localparam int TW = $clog2(TIMEOUT + 1);

    dma_state_t       state;
    logic [29:0]      src_ptr, dst_ptr;
    logic [LEN_W-1:0] rem;
    logic [TW-1:0]    tmo;
    logic             abort_pend;
    logic             ack;
    logic             unused_lsbs;

    assign ack         = wbm_ack_i & wbm_cyc_o & wbm_stb_o;
    assign wbm_sel_o   = SEL_ALL;
    assign unused_lsbs = ^{src_i[1:0], dst_i[1:0]};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            rem        <= '0;
            tmo        <= '0;
            abort_pend <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            words_o    <= '0;
            wbm_adr_o  <= '0;
            wbm_dat_o  <= '0;
            wbm_we_o   <= 1'b0;
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
        end else begin
            done_o     <= 1'b0;
            abort_pend <= abort_pend | abort_i;
            case (state)
                IDLE: begin
                    abort_pend <= 1'b0;
                    if (start_i) begin
                        src_ptr <= src_i[31:2];
                        dst_ptr <= dst_i[31:2];
                        rem     <= len_i;
                        err_o   <= 1'b0;
                        words_o <= '0;
                        busy_o  <= 1'b1;
                        state   <= (len_i == '0) ? FIN : RD;
                    end
                end
                RD, WR: begin
                    // each transfer starts from a deasserted strobe, then waits for ack or timeout
                    if (!wbm_stb_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= (state == WR);
                        wbm_adr_o <= word_adr((state == WR) ? dst_ptr : src_ptr);
                        tmo       <= '0;
                    end else if (ack) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        if (state == RD) begin
                            wbm_dat_o <= wbm_dat_i;
                            state     <= WR;
                        end else begin
                            src_ptr <= src_ptr + 30'd1;
                            dst_ptr <= dst_ptr + 30'd1;
                            rem     <= rem - LEN_W'(1);
                            words_o <= words_o + LEN_W'(1);
                            state   <= (rem == LEN_W'(1) || abort_pend || abort_i) ? FIN : GAP;
                        end
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        err_o     <= 1'b1;
                        state     <= FIN;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                GAP: state <= (abort_pend || abort_i) ? FIN : RD;
                FIN: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/wb_dma_copy.md
Name: wb_dma_copy

Overview:
- Wishbone initiator (master) that copies a block of 32-bit words from a source address to a destination address. It issues one read then one write per word, with a single transaction outstanding at a time.
- Sits beside the management core on the Wishbone bus and targets word-addressed responders such as the on-chip SRAM wrappers.
- Configured and started through a simple control port; reports busy, done and error.

Parameters:
- LEN_W, 16, width of the word-count input and internal counter.
- TIMEOUT, 255, maximum cycles to wait for wb_ack_i per transaction before aborting with an error.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle pulse that starts a copy; ignored while busy_o=1
- abort_i  in  1  stops the copy after the current bus cycle ends (ack or timeout)
- src_i  in  32  source byte address; bits [1:0] are ignored
- dst_i  in  32  destination byte address; bits [1:0] are ignored
- len_i  in  LEN_W  number of words to copy
- busy_o  out  1  high from the cycle after an accepted start until the terminal state
- done_o  out  1  one-cycle pulse when the copy ends, whether normally, aborted or errored
- err_o  out  1  sticky timeout flag; cleared on the next accepted start
- words_o  out  LEN_W  number of words fully written so far
- wbm_adr_o  out  32  bus address, always word-aligned ([1:0]=0)
- wbm_dat_o  out  32  write data
- wbm_sel_o  out  4  byte selects, always 4'hF
- wbm_we_o  out  1  write enable
- wbm_cyc_o  out  1  bus cycle
- wbm_stb_o  out  1  strobe
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  responder acknowledge

Behaviour:
- Reset, one edge, including mid-transfer:
  - FSM goes to IDLE.
  - cyc, stb, we, busy, done and err are 0; adr, dat and words are 0; sel is 4'hF.
  - Any in-flight bus cycle is dropped; no ack is awaited afterwards.
- FSM states: IDLE, RD, WR, GAP, FIN.
- IDLE, start_i=1:
  - Latch src[31:2], dst[31:2] and len; clear err and words; set busy.
  - If len=0, go to FIN (no bus activity). Otherwise go to RD.
- RD:
  - Drive cyc=stb=1, we=0, adr={src_ptr,2'b00}.
  - On ack: capture wbm_dat_i into the data buffer, drop cyc and stb on the next edge, go to WR.
- WR:
  - Drive cyc=stb=1, we=1, adr={dst_ptr,2'b00}, dat=buffer.
  - On ack: drop cyc and stb; src_ptr+1, dst_ptr+1, remaining-1, words+1.
  - If remaining becomes 0, or abort is pending, go to FIN; else go to GAP.
- GAP: one idle cycle with cyc=stb=0, then go to RD. This guarantees a strobe deassertion between transactions.
- FIN: for one cycle, done_o=1 and busy_o=0 on the following edge; then return to IDLE.
- Read latency: any number of cycles ≥1. A read ack arriving 2 cycles after stb rises must be accepted.
- Acks while cyc=0 are ignored.
- Timeout:
  - The counter resets on entry to RD or WR and increments each cycle stb=1 without ack.
  - When it reaches TIMEOUT: drop cyc and stb, set err_o, go to FIN. words_o keeps the count of completed writes.
- abort_i: latched as pending. It takes effect only after the current RD→WR pair completes, so a read word is never dropped without its write. The exception is a timeout, which ends the transfer immediately.
- Address wrap: the pointers are 30-bit and wrap modulo 2^30 silently.
- start_i with abort_i in the same IDLE cycle: the start is accepted and the abort is ignored.

Decomposition:
- Shared package wb_pkg:
  - Wishbone constants: SEL_ALL=4'hF, word address shift=2.
  - FSM state enum for this block.
- No sub-module required; the timeout counter is a small inline counter.

Test Plan:
- Basic copy: src=0x100, dst=0x200, len=3, responder acks 1 cycle after stb on writes and 2 cycles on reads → reads at 0x100/0x104/0x108 and writes of the same data to 0x200/0x204/0x208; done pulses once; words_o=3; err_o=0.
- Zero length: len=0 → cyc never asserted; done pulses 2 cycles after start; words_o=0.
- Timeout: responder never acks the 2nd read, TIMEOUT=8 → cyc drops after 8 stb cycles; err_o=1; done pulses; words_o=1.
- Abort: len=10, abort_i asserted during the 3rd read → the 3rd write completes; done pulses; words_o=3; no further cyc.
- Reset mid-write: assert wb_rst_i while WR stb=1 → next edge cyc=stb=0, busy=0; a new start then copies correctly.
- Start while busy: second start_i pulse during the copy → ignored; src, dst and len are unchanged; single done pulse.
